// File: rtl/vx_itcm_responder_pkg.sv
// Shared ITCM constants and the word-index helper used by the responder.
package vx_itcm_responder_pkg;

  localparam int unsigned ITCM_WORD_WIDTH   = 32;
  localparam int unsigned ITCM_BYTEEN_WIDTH = 4;

  // Upper address bits are dropped, so the array aliases across the address space.
  function automatic logic [31:0] itcm_index(input logic [63:0] addr, input int unsigned idx_bits);
    logic [63:0] mask;
    mask = (64'd1 << idx_bits) - 64'd1;
    return 32'(addr & mask);
  endfunction

endpackage

// File: rtl/vx_itcm_responder_if.sv
// Fetch-side request/response bus between the icache client and the ITCM.
interface vx_itcm_responder_if
  import vx_itcm_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned TAG_WIDTH  = 12
);
  logic                         req_valid;
  logic                         req_rw;
  logic [ADDR_WIDTH-1:0]        req_addr;
  logic [ITCM_BYTEEN_WIDTH-1:0] req_byteen;
  logic [ITCM_WORD_WIDTH-1:0]   req_data;
  logic [TAG_WIDTH-1:0]         req_tag;
  logic                         req_ready;
  logic                         rsp_valid;
  logic [ITCM_WORD_WIDTH-1:0]   rsp_data;
  logic [TAG_WIDTH-1:0]         rsp_tag;
  logic                         rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/vx_itcm_responder_rsp_queue.sv
// First-word-fall-through response FIFO; head entry is visible whenever not empty.
module vx_itcm_responder_rsp_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 44
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push_i && full_o)) else $error("rsp queue: push while full");
      assert (!(pop_i && empty_o)) else $error("rsp queue: pop while empty");
    end
  end

endmodule

// File: rtl/vx_itcm_responder.sv
// ITCM responder: byte-enabled sync SRAM, one read pipeline stage and an in-order response queue.
module vx_itcm_responder
  import vx_itcm_responder_pkg::*;
#(
  parameter int unsigned NUM_WORDS      = 4096,
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned TAG_WIDTH      = 12,
  parameter int unsigned RSP_QUEUE_SIZE = 4,
  parameter              INIT_FILE      = ""
) (
  input  logic               clk,
  input  logic               reset,
  vx_itcm_responder_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned CNT_W = $clog2(RSP_QUEUE_SIZE) + 1;
  localparam int unsigned ENT_W = ITCM_WORD_WIDTH + TAG_WIDTH;

  logic [ITCM_WORD_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [IDX_W-1:0]           idx;
  logic                       req_fire;
  logic                       rd_fire;
  logic                       wr_fire;
  logic                       rsp_fire;

  logic                       s1_valid_q;
  logic [ITCM_WORD_WIDTH-1:0] s1_data_q;
  logic [TAG_WIDTH-1:0]       s1_tag_q;

  logic [CNT_W-1:0]           credit_q;
  logic [CNT_W-1:0]           credit_d;

  logic [ENT_W-1:0]           q_head;
  logic                       q_empty;
  logic                       q_full;
  logic [CNT_W-1:0]           q_count;

  assign idx      = IDX_W'(itcm_index(64'(bus.req_addr), IDX_W));
  // Credits cover s1 plus the queue, so an s1 push can never find the queue full.
  assign bus.req_ready = !reset && (credit_q < CNT_W'(RSP_QUEUE_SIZE));
  assign req_fire = bus.req_valid && bus.req_ready;
  assign rd_fire  = req_fire && !bus.req_rw;
  assign wr_fire  = req_fire && bus.req_rw;
  assign bus.rsp_valid = !q_empty;
  assign rsp_fire = bus.rsp_valid && bus.rsp_ready;
  assign {bus.rsp_data, bus.rsp_tag} = q_head;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned b = 0; b < ITCM_BYTEEN_WIDTH; b++) begin
        if (bus.req_byteen[b]) mem_q[idx][b*8 +: 8] <= bus.req_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire) begin
      s1_data_q <= mem_q[idx];
      s1_tag_q  <= bus.req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= rd_fire;
  end

  always_comb begin
    credit_d = credit_q;
    case ({rd_fire, rsp_fire})
      2'b10:   credit_d = credit_q + CNT_W'(1);
      2'b01:   credit_d = credit_q - CNT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) credit_q <= '0;
    else       credit_q <= credit_d;
  end

  vx_itcm_responder_rsp_queue #(
    .DEPTH (RSP_QUEUE_SIZE),
    .WIDTH (ENT_W)
  ) u_rsp_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s1_valid_q),
    .data_i  ({s1_data_q, s1_tag_q}),
    .pop_i   (rsp_fire),
    .data_o  (q_head),
    .empty_o (q_empty),
    .full_o  (q_full),
    .count_o (q_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(s1_valid_q && q_full)) else $error("itcm: s1 push into full queue");
      assert (!(bus.req_valid && $isunknown(bus.req_addr))) else $error("itcm: X request address");
      assert (credit_q == CNT_W'(s1_valid_q) + q_count) else $error("itcm: credit count drift");
    end
  end

endmodule
